// File: rtl/sine_nco.sv
// sine_nco: pipelined fixed-point sine/cosine NCO built on a quarter-wave LUT,
// with quadrant folding and optional linear interpolation between table points.
module sine_nco #(
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 8,
    parameter int FRAC_W     = 8,
    parameter int DATA_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic [PHASE_W-1:0]       phase_inc_i,
    input  logic [PHASE_W-1:0]       phase_off_i,
    input  logic                     interp_i,
    output logic                     valid_o,
    output logic signed [DATA_W-1:0] sin_o,
    output logic signed [DATA_W-1:0] cos_o
);
    localparam int N   = 2 ** LUT_ADDR_W;
    localparam int MW  = LUT_ADDR_W + 2;
    localparam int TW  = MW + FRAC_W;
    localparam int PW  = DATA_W + FRAC_W + 2;
    localparam int AMP = 2 ** (DATA_W - 1) - 1;
    localparam logic [LUT_ADDR_W:0]  N_IDX = (LUT_ADDR_W + 1)'(N);
    localparam logic signed [PW-1:0] AMP_P = PW'(AMP);

    if (PHASE_W < TW) begin : g_bad_cfg
        $error("sine_nco: PHASE_W must be >= 2 + LUT_ADDR_W + FRAC_W");
    end

    typedef logic [N:0][DATA_W-1:0] lut_t;

    function automatic lut_t build_lut();
        lut_t t;
        for (int k = 0; k <= N; k++)
            t[k] = DATA_W'($rtoi($sin(3.141592653589793 / 2.0 * k / N) * AMP + 0.5));
        return t;
    endfunction

    localparam lut_t LUT = build_lut();

    // Full-wave sample from the quarter table: odd quadrants mirror, upper half negates.
    function automatic logic signed [DATA_W-1:0] wave(input logic [MW-1:0] m);
        logic [LUT_ADDR_W:0]       idx;
        logic signed [DATA_W-1:0]  v;
        idx = m[MW-2] ? N_IDX - {1'b0, m[LUT_ADDR_W-1:0]} : {1'b0, m[LUT_ADDR_W-1:0]};
        v   = LUT[idx];
        return m[MW-1] ? -v : v;
    endfunction

    function automatic logic signed [PW-1:0] scale(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b,
                                                   input logic [FRAC_W-1:0] f);
        logic signed [DATA_W:0] d;
        d = (DATA_W + 1)'(b) - (DATA_W + 1)'(a);
        return PW'(d) * PW'($signed({1'b0, f}));
    endfunction

    // Arithmetic shift gives floor of the interpolated step; clamp keeps the range symmetric.
    function automatic logic signed [DATA_W-1:0] finish(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = PW'(a) + (p >>> FRAC_W);
        return (s > AMP_P) ? DATA_W'(AMP) : (s < -AMP_P) ? DATA_W'(-AMP) : s[DATA_W-1:0];
    endfunction

    logic [PHASE_W-1:0]       acc_q, acc_d, p_d;
    logic [TW-1:0]            p1_q;
    logic                     v1_q, i1_q, v2_q, v3_q, valid_q;
    logic [MW-1:0]            m;
    logic [FRAC_W-1:0]        f, f2_q, f_d;
    logic signed [DATA_W-1:0] sa_d, sb_d, ca_d, cb_d, sa2_q, sb2_q, ca2_q, cb2_q;
    logic signed [DATA_W-1:0] sa3_q, ca3_q, sin_d, cos_d, sin_q, cos_q;
    logic signed [PW-1:0]     sp_d, cp_d, sp3_q, cp3_q;

    if (PHASE_W > TW) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^p_d[PHASE_W-TW-1:0];
    end

    always_comb begin
        acc_d = load_i ? '0 : (en_i ? acc_q + phase_inc_i : acc_q);
        p_d   = acc_q + phase_off_i;
        m     = p1_q[TW-1 -: MW];
        f     = p1_q[FRAC_W-1:0];
        f_d   = i1_q ? f : '0;
        sa_d  = wave(m);
        sb_d  = wave(m + MW'(1));
        ca_d  = wave(m + MW'(N));
        cb_d  = wave(m + MW'(N + 1));
        sp_d  = scale(sa2_q, sb2_q, f2_q);
        cp_d  = scale(ca2_q, cb2_q, f2_q);
        sin_d = finish(sa3_q, sp3_q);
        cos_d = finish(ca3_q, cp3_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            p1_q    <= '0;
            v1_q    <= 1'b0;
            i1_q    <= 1'b0;
            v2_q    <= 1'b0;
            f2_q    <= '0;
            sa2_q   <= '0;
            sb2_q   <= '0;
            ca2_q   <= '0;
            cb2_q   <= '0;
            v3_q    <= 1'b0;
            sa3_q   <= '0;
            ca3_q   <= '0;
            sp3_q   <= '0;
            cp3_q   <= '0;
            valid_q <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            p1_q    <= p_d[PHASE_W-1 -: TW];
            v1_q    <= en_i;
            i1_q    <= interp_i;
            v2_q    <= v1_q;
            f2_q    <= f_d;
            sa2_q   <= sa_d;
            sb2_q   <= sb_d;
            ca2_q   <= ca_d;
            cb2_q   <= cb_d;
            v3_q    <= v2_q;
            sa3_q   <= sa2_q;
            ca3_q   <= ca2_q;
            sp3_q   <= sp_d;
            cp3_q   <= cp_d;
            valid_q <= v3_q;
            if (v3_q) begin
                sin_q <= sin_d;
                cos_q <= cos_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign sin_o   = sin_q;
    assign cos_o   = cos_q;
endmodule

// File: tb/tb_sine_nco.sv
// tb_sine_nco: table-driven and randomised scoreboard bench for sine_nco,
// with hand-written reset and latency sequences.
module tb_sine_nco;
    logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, load_i = 1'b0, interp_i = 1'b0;
    logic [31:0] phase_inc_i = '0, phase_off_i = '0;
    logic valid_o;
    logic signed [15:0] sin_o, cos_o;

    sine_nco dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .load_i(load_i),
        .phase_inc_i(phase_inc_i), .phase_off_i(phase_off_i), .interp_i(interp_i),
        .valid_o(valid_o), .sin_o(sin_o), .cos_o(cos_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic en; logic ld; logic [31:0] inc; logic [31:0] off; logic ip; int es; int ec;} vec_t;
    typedef struct {int s; int c;} exp_t;

    localparam logic [31:0] Q = 32'h4000_0000;
    localparam logic [31:0] H = 32'h0020_0000;

    vec_t tbl[$];
    exp_t exp_q[$];
    int q[0:256];
    int checks = 0, passes = 0, last_s = 0, last_c = 0, cnt;
    logic [31:0] macc = '0;
    logic [3:0] vh = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int wave(input int m);
        int i, qd;
        i  = m % 256;
        qd = m / 256;
        case (qd)
            0: return q[i];
            1: return q[256 - i];
            2: return -q[i];
            default: return -q[256 - i];
        endcase
    endfunction

    function automatic int model(input logic [31:0] p, input logic ip, input bit c);
        int m, f, s0, s1, r;
        m = int'(p[31:22]);
        f = int'(p[21:14]);
        if (c) m = (m + 256) % 1024;
        s0 = wave(m);
        s1 = wave((m + 1) % 1024);
        r  = ip ? s0 + int'($floor(real'((s1 - s0) * f) / 256.0)) : s0;
        return r > 32767 ? 32767 : (r < -32767 ? -32767 : r);
    endfunction

    task automatic check_out();
        exp_t e;
        chk("valid", int'(valid_o), int'(vh[3]));
        if (valid_o) begin
            if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sin", int'(sin_o), e.s);
                chk("cos", int'(cos_o), e.c);
                last_s = e.s;
                last_c = e.c;
            end
        end else begin
            chk("hold_sin", int'(sin_o), last_s);
            chk("hold_cos", int'(cos_o), last_c);
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [31:0] inc,
                        input logic [31:0] off, input logic ip, input int es, input int ec);
        en_i = en; load_i = ld; phase_inc_i = inc; phase_off_i = off; interp_i = ip;
        if (en) exp_q.push_back('{es, ec});
        macc = ld ? 32'd0 : (en ? macc + inc : macc);
        @(posedge clk); #1;
        vh = {vh[2:0], en};
        check_out();
    endtask

    initial begin
        logic [31:0] inc, off;
        logic ip, en, ld;
        for (int k = 0; k <= 256; k++)
            q[k] = int'($floor($sin(3.141592653589793 / 2.0 * k / 256.0) * 32767.0 + 0.5));
        // DC phase
        repeat (3) tbl.push_back('{1, 0, 0, 0, 1, 0, 32767});
        // quarter-turn stepping
        tbl.push_back('{1, 0, Q, 0, 1, 0, 32767});
        tbl.push_back('{1, 0, Q, 0, 1, 32767, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 0, -32767});
        tbl.push_back('{1, 0, Q, 0, 1, -32767, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 0, 32767});
        // load with en uses old phase, then interpolation at f = 128
        tbl.push_back('{1, 1, 0, 0, 1, 32767, 0});
        tbl.push_back('{1, 0, 0, H, 1, 100, 32766});
        tbl.push_back('{1, 0, 0, H, 0, 0, 32767});
        tbl.push_back('{1, 0, 0, H, 1, 100, 32766});
        tbl.push_back('{1, 0, 0, H, 0, 0, 32767});
        tbl.push_back('{1, 0, 0, H, 1, 100, 32766});
        tbl.push_back('{1, 0, 0, H, 0, 0, 32767});
        // enable gaps 1,0,0,1
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 0, 32767});
        tbl.push_back('{0, 0, Q, 0, 1, 0, 0});
        tbl.push_back('{0, 0, Q, 0, 1, 0, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 32767, 0});
        // wrap from 2^32 - 2^30, then load mid-run
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 3 * Q, 0, 1, 0, 32767});
        tbl.push_back('{1, 0, Q, 0, 1, -32767, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 0, 32767});
        tbl.push_back('{1, 1, Q, 0, 1, 32767, 0});
        tbl.push_back('{1, 0, Q, 0, 1, 0, 32767});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_sin", int'(sin_o), 0);
        chk("reset_cos", int'(cos_o), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i].en, tbl[i].ld, tbl[i].inc, tbl[i].off, tbl[i].ip, tbl[i].es, tbl[i].ec);

        for (int i = 0; i < 40; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 9) == 0);
            inc = $urandom;
            off = $urandom;
            ip  = 1'($urandom_range(0, 1));
            step(en, ld, inc, off, ip, model(macc + off, ip, 0), model(macc + off, ip, 1));
        end
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);
        chk("drain", exp_q.size(), 0);

        // asynchronous reset mid-stream
        en_i = 1'b1; load_i = 1'b0; phase_inc_i = Q; phase_off_i = 0; interp_i = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(valid_o), 0);
        chk("async_reset_sin", int'(sin_o), 0);
        chk("async_reset_cos", int'(cos_o), 0);
        en_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // first-sample latency after release
        en_i = 1'b1; phase_inc_i = 0; phase_off_i = 0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            en_i = 1'b0;
            cnt++;
        end while (!valid_o && cnt < 10);
        chk("latency", cnt, 4);
        chk("latency_sin", int'(sin_o), 0);
        chk("latency_cos", int'(cos_o), 32767);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
- Parametrised, pipelined sine/cosine generator (NCO) that replaces the combinational real-valued sine lookup with synthesizable fixed-point hardware.
- Holds a phase accumulator and a quarter-wave LUT built at elaboration, uses quadrant symmetry, and optionally interpolates linearly between table points.
- Produces paired signed sin/cos samples with a valid strobe for the downstream signal-processing datapath.

Parameters:
- PHASE_W, 32, phase accumulator width; one full turn = 2^PHASE_W.
- LUT_ADDR_W, 8, quarter-wave index bits; table depth N = 2^LUT_ADDR_W (+1 entry).
- FRAC_W, 8, interpolation fraction bits.
- DATA_W, 16, signed output width.
- Constraint: PHASE_W >= 2 + LUT_ADDR_W + FRAC_W. Violation is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  issue a sample this cycle and advance the accumulator.
- load_i  in  1  synchronous accumulator clear.
- phase_inc_i  in  PHASE_W  unsigned tuning word.
- phase_off_i  in  PHASE_W  unsigned phase offset, added per sample.
- interp_i  in  1  1 = linear interpolation, 0 = nearest-lower table point.
- valid_o  out  1  sin_o/cos_o hold a new sample.
- sin_o  out  DATA_W  signed two's-complement sine.
- cos_o  out  DATA_W  signed two's-complement cosine.

Behaviour:
- Reset: rst_n low asynchronously clears the accumulator, all pipeline registers, valid_o, sin_o and cos_o to 0. Any in-flight samples are discarded. The first valid sample appears no earlier than 4 cycles after the first en_i following release.
- Table: q[k] = round(sin(pi/2 * k/N) * (2^(DATA_W-1) - 1)), k = 0..N. The table is a constant computed at elaboration.
- Full-wave sample: for m in 0..4N-1, quadrant Q = m/N and i = m mod N.
  - Q0: +q[i]
  - Q1: +q[N-i]
  - Q2: -q[i]
  - Q3: -q[N-i]
- Phase fields of p = acc + phase_off_i (mod 2^PHASE_W):
  - m = p[PHASE_W-1 -: 2+LUT_ADDR_W]
  - f = next FRAC_W bits below m
  - remaining LSBs are ignored (truncated)
- Sine output:
  - interp_i = 1: sin = s(m) + floor((s((m+1) mod 4N) - s(m)) * f / 2^FRAC_W), using an arithmetic shift.
  - interp_i = 0: sin = s(m).
- Cosine: the same computation with m replaced by (m + N) mod 4N.
- Results are clamped to ±(2^(DATA_W-1) - 1); -2^(DATA_W-1) is never output.
- Accumulator update: acc(t+1) = load_i ? 0 : (en_i ? acc(t) + phase_inc_i : acc(t)), modulo 2^PHASE_W. Wrap-around is silent.
- Load behaviour: load_i takes priority over en_i. The sample issued in a load cycle (if en_i = 1) uses the pre-load acc(t). The next issued sample uses phase 0 + offset.
- Pipeline: 4 stages, free-running, with valid carried alongside the data.
  - S1: register p and interp_i.
  - S2: four LUT reads plus quadrant sign/mirror.
  - S3: difference × f.
  - S4: add, clamp, register outputs.
- Timing: a sample issued at cycle t (en_i = 1) gives valid_o = 1 at t+4, with phase_off_i and interp_i sampled at t.
- Output hold: when valid_o = 0, sin_o/cos_o keep their last values.
- en_i gaps produce exactly matching valid_o gaps; the accumulator holds during gaps.

Test Plan:
- Reset: rst_n = 0 mid-stream with en_i = 1 -> valid_o, sin_o, cos_o all 0 within the same cycle. After release and en_i = 1, the first valid_o appears exactly 4 cycles later.
- DC phase: inc = 0, off = 0, interp = 1, en continuous -> from cycle 4: sin_o = 0, cos_o = 32767, valid_o held high.
- Quarter-turn stepping: inc = 2^30 -> sin_o sequence 0, 32767, 0, -32767 repeating; cos_o sequence 32767, 0, -32767, 0 repeating.
- Interpolation: inc = 0, off = 2^21 (f = 128 at index 0).
  - interp = 1 -> sin_o = 100 (q[1] = 201).
  - interp = 0 -> sin_o = 0.
  - Toggling interp_i per cycle -> outputs alternate 100/0 with 4-cycle alignment.
- Wrap and load: acc starts at 2^32 - 2^30, inc = 2^30 -> next sin = 0 (wrap to phase 0). Assert load_i with en_i = 1 mid-run -> that sample uses the old phase; the following sample is sin = 0, cos = 32767.
- Enable gaps: en_i pattern 1,0,0,1 with inc = 2^30 -> valid_o pattern 1,0,0,1 delayed 4 cycles; the second sample equals sin = 32767 (the accumulator held during the gap).
